// File: rtl/pinwheel_debug_pkg.sv
// Shared constants for the pinwheel debug-register window: register word
// indices, STATUS bit layout and the default address tag.
package pinwheel_debug_pkg;

  localparam logic [3:0] DBG_BASE_TAG = 4'hF;

  // Word indices (bus_addr[7:2]) of the debug registers.
  localparam logic [5:0] DBG_CONSOLE_TX = 6'h00;
  localparam logic [5:0] DBG_STATUS     = 6'h01;
  localparam logic [5:0] DBG_TICKS_LO   = 6'h02;
  localparam logic [5:0] DBG_TICKS_HI   = 6'h03;
  localparam logic [5:0] DBG_SCRATCH    = 6'h04;
  localparam logic [5:0] DBG_TOHOST     = 6'h05;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;

endpackage

// File: rtl/pinwheel_byte_fifo.sv
// Console byte FIFO: power-of-two depth, wrapping pointers, drops pushes
// that arrive while full with no pop, and records that in a sticky flag.
module pinwheel_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_ready,
  input  logic          overflow_clr,
  output logic          valid,
  output logic [7:0]    head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  // Handshake: valid (count != 0) with head_data held stable until the sink
  // raises pop_ready; a byte leaves exactly on a cycle with valid && pop_ready.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;
  logic          push_ok;

  assign valid     = (count != '0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];
  assign pop       = valid && pop_ready;
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped push outranks a same-cycle software clear.
      if (push && !push_ok)  overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/pinwheel_debug_regs.sv
// Debug-register responder for the pinwheel 0xFxxxxxxx data-bus window.
// Optional TOHOST register and test_done/test_pass ports: PINWHEEL_DEBUG_TOHOST_EN.
module pinwheel_debug_regs
  import pinwheel_debug_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] BASE_TAG   = DBG_BASE_TAG
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wren,
  output logic [31:0] bus_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
`ifdef PINWHEEL_DEBUG_TOHOST_EN
  output logic        test_done,
  output logic        test_pass,
`endif
  output logic        irq_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          cs;
  logic          wr;
  logic [5:0]    reg_idx;
  logic [CW-1:0] fifo_count;
  logic [8:0]    count_wide;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow;
  logic          tx_push;
  logic          ovf_clr;
  logic [63:0]   ticks;
  logic [31:0]   shadow_hi;
  logic [31:0]   scratch;
  logic [31:0]   status_val;
  logic [31:0]   rd_val;
  logic          unused_addr_bits;

  assign cs      = (bus_addr[31:28] == BASE_TAG);
  assign wr      = cs && bus_wren;
  assign reg_idx = bus_addr[7:2];
  assign tx_push = wr && (reg_idx == DBG_CONSOLE_TX) && bus_wmask[0];
  assign ovf_clr = wr && (reg_idx == DBG_STATUS) && bus_wmask[0] &&
                   bus_wdata[STATUS_OVERFLOW_BIT];
  // Upper address bits alias the window; byte offset is meaningless.
  assign unused_addr_bits = ^{bus_addr[27:8], bus_addr[1:0]};

  pinwheel_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (tx_push),
    .push_data    (bus_wdata[7:0]),
    .pop_ready    (console_ready),
    .overflow_clr (ovf_clr),
    .valid        (console_valid),
    .head_data    (console_data),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .overflow     (overflow)
  );

  assign irq_overflow = overflow;
  assign count_wide   = 9'(fifo_count);

  always_comb begin
    status_val = '0;
    status_val[STATUS_COUNT_LSB +: 8]  = count_wide[7:0];
    status_val[STATUS_OVERFLOW_BIT]    = overflow;
    status_val[STATUS_FULL_BIT]        = fifo_full;
    status_val[STATUS_EMPTY_BIT]       = fifo_empty;
  end

`ifdef PINWHEEL_DEBUG_TOHOST_EN
  logic [31:0] tohost;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tohost    <= '0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
    end else if (wr && (reg_idx == DBG_TOHOST)) begin
      tohost    <= bus_wdata;
      test_pass <= (bus_wdata == 32'd1);
      if (bus_wdata != '0) test_done <= 1'b1;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      DBG_STATUS:   rd_val = status_val;
      DBG_TICKS_LO: rd_val = ticks[31:0];
      DBG_TICKS_HI: rd_val = shadow_hi;
      DBG_SCRATCH:  rd_val = scratch;
`ifdef PINWHEEL_DEBUG_TOHOST_EN
      DBG_TOHOST:   rd_val = tohost;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_rdata <= '0;
      ticks     <= '0;
      shadow_hi <= '0;
      scratch   <= '0;
    end else begin
      bus_rdata <= cs ? rd_val : '0;
      ticks     <= ticks + 64'd1;
      // Reading LO freezes HI so a LO-then-HI pair is tear-free.
      if (cs && (reg_idx == DBG_TICKS_LO)) shadow_hi <= ticks[63:32];
      if (wr && (reg_idx == DBG_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (bus_wmask[b]) scratch[8*b +: 8] <= bus_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/pinwheel_debug_regs.md
Name: pinwheel_debug_regs

Overview:
Data-bus responder for the 0xFxxxxxxx debug-register window driven by the pinwheel core's bus initiator outputs. Decodes word-addressed debug registers: console TX FIFO with drain handshake, 64-bit tick counter with snapshot, scratch register, status. Returns read data one cycle after the address, in time for phase-C regfile writeback. Sits beside data RAM on the shared data bus; its rdata is muxed into the core's bus read data.

Parameters:
FIFO_DEPTH, 8, console FIFO entries; power of two, 2..256
BASE_TAG, 4'hF, bus_addr[31:28] value selecting this block

Ports:
clock  in  1  global clock
reset_n  in  1  asynchronous active-low reset
bus_addr  in  32  byte address from core (phase B)
bus_wdata  in  32  store data
bus_wmask  in  4  byte write mask
bus_wren  in  1  store strobe
bus_rdata  out  32  registered read data, valid cycle after address
console_valid  out  1  FIFO head byte available
console_data  out  8  FIFO head byte
console_ready  in  1  sink accepts head byte this cycle
irq_overflow  out  1  sticky console overflow flag

Behaviour:
- cs = bus_addr[31:28]==BASE_TAG; reg index = bus_addr[7:2]; bus_addr[27:8] ignored (aliases). Writes require cs && bus_wren.
- Reads have no side effects except TICKS_LO snapshot. bus_rdata <= decoded value every cycle cs is high; 0 when cs low. Latency exactly 1 cycle.
- 0x00 CONSOLE_TX: write with wmask[0] pushes wdata[7:0]; reads 0.
- 0x04 STATUS: read {16'b0, count[7:0], 5'b0, overflow, full, empty}. Writing 1 to bit2 with wmask[0] clears overflow.
- 0x08 TICKS_LO: read returns ticks[31:0]; same cycle latches ticks[63:32] into shadow_hi.
- 0x0C TICKS_HI: read returns shadow_hi (not live).
- 0x10 SCRATCH: RW, per-byte wmask.
- Other indices: read 0, writes ignored.
- ticks: 64-bit, +1 every cycle, wraps 2^64-1 -> 0.
- FIFO: count 0..FIFO_DEPTH, wrapping rd/wr pointers. pop = console_valid && console_ready. push accepted if count<FIFO_DEPTH or pop same cycle. Push at full without pop: dropped, overflow <= 1 (sticky). Push+pop same cycle: count unchanged.
- Overflow set and clear same cycle: set wins.
- console_valid = count!=0; console_data = mem[rd_ptr], stable while valid && !ready.
- irq_overflow = overflow.
- Reset (async assert, sync deassert externally): bus_rdata=0, count=0, pointers=0, overflow=0, ticks=0, shadow_hi=0, scratch=0, console_valid=0. Mid-operation reset discards FIFO contents.

Optional Feature:
PINWHEEL_DEBUG_TOHOST_EN: adds 0x14 TOHOST reg plus outputs test_done(1), test_pass(1). Write sets tohost=wdata (full word, ignoring wmask). Any nonzero write sets test_done=1 sticky until reset; test_pass=1 iff written value==1. Reads return tohost. Without macro: 0x14 reads 0, ports absent.

Decomposition:
Package pinwheel_debug_pkg: register index localparams (DBG_CONSOLE_TX, DBG_STATUS, DBG_TICKS_LO, DBG_TICKS_HI, DBG_SCRATCH, DBG_TOHOST), STATUS bit positions, BASE_TAG default. One sub-module: pinwheel_byte_fifo (parameterized depth, push/pop/full/empty/count, overflow-drop policy); the register decode stays in the top.

Test Plan:
- Reset then read 0xF0000004 -> next-cycle bus_rdata=0x00000001 (empty), console_valid=0.
- Write 0x41,0x42 to 0xF0000000 with console_ready=0 -> STATUS=0x00000200; ready=1 -> console_data 0x41 then 0x42, then empty.
- Push 9 bytes with ready=0, FIFO_DEPTH=8 -> 9th dropped, STATUS=0x00000806, irq_overflow=1; write 0x4 to STATUS -> overflow=0, data bytes 1..8 intact.
- At full, push with ready=1 same cycle -> accepted, count stays 8, overflow stays 0.
- Force ticks=0x00000000_FFFFFFFF, read LO then HI two cycles later -> LO=0xFFFFFFFF, HI=0x00000000 (snapshot, not post-carry 1).
- SCRATCH write 0xDEADBEEF wmask 4'b0101 over 0 -> read 0x00AD00EF; bus_addr tag 0x8 reads -> bus_rdata=0, no writes occur.
